// File: rtl/id_stage_pkg.sv
// +------------------------------------------------------------------+
// | id_stage_pkg: RV32I ALU-subset opcode, funct3 and funct7 values.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package id_stage_pkg;

  localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_LUI      = 7'b0110111;
  localparam logic [6:0] INST_AUIPC    = 7'b0010111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SR      = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // funct7 legality for OP-IMM shifts and OP; other opcodes carry no funct7
  function automatic logic funct7_ok(input logic [6:0] opcode,
                                     input logic [2:0] funct3,
                                     input logic [6:0] funct7);
    logic ok;
    ok = 1'b1;
    if (opcode == INST_TYPE_I) begin
      if (funct3 == FUNCT3_SLL)
        ok = (funct7 == FUNCT7_BASE);
      else if (funct3 == FUNCT3_SR)
        ok = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
    end else if (opcode == INST_TYPE_R_M) begin
      ok = (funct7 == FUNCT7_BASE) ||
           ((funct7 == FUNCT7_ALT) &&
            ((funct3 == FUNCT3_ADD_SUB) || (funct3 == FUNCT3_SR)));
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_decode_comb.sv
// +------------------------------------------------------------------+
// | id_decode_comb: combinational RV32I ALU-subset decode.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module id_decode_comb
  import id_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              valid_i,
  input  logic [31:0]       inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_wen_o,
  output logic              illegal_o
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];
  assign w_funct7 = inst_i[31:25];

  always_comb begin
    rs1_addr_o = '0;
    rs2_addr_o = '0;
    op1_o      = '0;
    op2_o      = '0;
    rd_addr_o  = '0;
    reg_wen_o  = 1'b0;
    illegal_o  = 1'b1;

    case (w_opcode)
      INST_TYPE_I: begin
        illegal_o  = !funct7_ok(w_opcode, w_funct3, w_funct7);
        rs1_addr_o = inst_i[15 +: REG_AW];
        op1_o      = rs1_data_i;
        op2_o      = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
      end
      INST_TYPE_R_M: begin
        illegal_o  = !funct7_ok(w_opcode, w_funct3, w_funct7);
        rs1_addr_o = inst_i[15 +: REG_AW];
        rs2_addr_o = inst_i[20 +: REG_AW];
        op1_o      = rs1_data_i;
        op2_o      = rs2_data_i;
      end
      INST_LUI: begin
        illegal_o = 1'b0;
        op2_o     = {inst_i[31:12], 12'b0};
      end
      INST_AUIPC: begin
        illegal_o = 1'b0;
        op1_o     = inst_addr_i;
        op2_o     = {inst_i[31:12], 12'b0};
      end
      default: ;
    endcase

    if (illegal_o) begin
      op1_o = '0;
      op2_o = '0;
    end else begin
      rd_addr_o = inst_i[7 +: REG_AW];
      reg_wen_o = (inst_i[7 +: REG_AW] != '0);
    end

    // no register-file reads for an empty slot
    if (!valid_i) begin
      rs1_addr_o = '0;
      rs2_addr_o = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// +------------------------------------------------------------------+
// | id_stage: registered RV32I decode stage with valid/ready + flush.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module id_stage
  import id_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          REG_AW   = 5,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   inst_addr_o,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_wen_o,
  output logic              illegal_o
);

  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic [REG_AW-1:0] w_rd;
  logic              w_wen;
  logic              w_illegal;
  logic              w_accept;

  logic              valid_q,     valid_d;
  logic [31:0]       inst_q,      inst_d;
  logic [XLEN-1:0]   inst_addr_q, inst_addr_d;
  logic [XLEN-1:0]   op1_q,       op1_d;
  logic [XLEN-1:0]   op2_q,       op2_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic              wen_q,       wen_d;
  logic              illegal_q,   illegal_d;

  id_decode_comb #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_decode (
    .valid_i     (in_valid_i),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .rs1_addr_o  (rs1_addr_o),
    .rs2_addr_o  (rs2_addr_o),
    .op1_o       (w_op1),
    .op2_o       (w_op2),
    .rd_addr_o   (w_rd),
    .reg_wen_o   (w_wen),
    .illegal_o   (w_illegal)
  );

  assign in_ready_o = !flush_i && (!valid_q || out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;

  always_comb begin
    valid_d     = valid_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    illegal_d   = illegal_q;

    if (flush_i) begin
      valid_d   = 1'b0;
      wen_d     = 1'b0;
      illegal_d = 1'b0;
      inst_d    = NOP_INST;
    end else if (w_accept) begin
      valid_d     = 1'b1;
      inst_d      = inst_i;
      inst_addr_d = inst_addr_i;
      op1_d       = w_op1;
      op2_d       = w_op2;
      rd_d        = w_rd;
      wen_d       = w_wen;
      illegal_d   = w_illegal;
    end else if (valid_q && out_ready_i) begin
      // drained with nothing behind it: data registers keep their contents
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      inst_q      <= NOP_INST;
      inst_addr_q <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid_o = valid_q;
  assign inst_o      = inst_q;
  assign inst_addr_o = inst_addr_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign rd_addr_o   = rd_q;
  assign reg_wen_o   = wen_q;
  assign illegal_o   = illegal_q;

endmodule

`default_nettype wire
